// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS control FSM (master) and the datapath (slave).
// The opcode and memory handshake flow into the controller; mux selects and strobes flow out.
interface mips_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic [1:0]       alu_op;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
               iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               instr_done, illegal, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
               iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               instr_done, illegal, instr_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, traps on unknown opcodes and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter bit ENABLE_ADDI = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        RWB,
        BRANCH,
        JUMP,
        ADDI_EX,
        ADDI_WB,
        TRAP
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             done;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            count <= '0;
        end else begin
            state <= next_state;
            if (done) begin
                count <= count + 1'b1;
            end
        end
    end

    // Outputs depend on state only, except the mem_ready-qualified strobes; all gated off during reset.
    always_comb begin
        next_state        = state;
        done              = 1'b0;
        bus.alu_op        = 2'b00;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.pc_source     = 2'b00;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.illegal       = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                    if (bus.mem_ready) begin
                        next_state = DECODE;
                    end
                end
                DECODE: begin
                    bus.alu_src_b = 2'b11;
                    case (bus.opcode)
                        OP_RTYPE: next_state = EXEC;
                        OP_LW:    next_state = MEMADR;
                        OP_SW:    next_state = MEMADR;
                        OP_BEQ:   next_state = BRANCH;
                        OP_J:     next_state = JUMP;
                        OP_ADDI:  next_state = ENABLE_ADDI ? ADDI_EX : TRAP;
                        default:  next_state = TRAP;
                    endcase
                end
                MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    next_state    = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                    if (bus.mem_ready) begin
                        next_state = MEMWB;
                    end
                end
                MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    done           = 1'b1;
                    next_state     = FETCH;
                end
                MEMWR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                    if (bus.mem_ready) begin
                        done       = 1'b1;
                        next_state = FETCH;
                    end
                end
                EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                    next_state    = RWB;
                end
                RWB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                    done          = 1'b1;
                    next_state    = FETCH;
                end
                BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                    done              = 1'b1;
                    next_state        = FETCH;
                end
                JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b10;
                    done          = 1'b1;
                    next_state    = FETCH;
                end
                ADDI_EX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    next_state    = ADDI_WB;
                end
                ADDI_WB: begin
                    bus.reg_write = 1'b1;
                    done          = 1'b1;
                    next_state    = FETCH;
                end
                TRAP: begin
                    bus.illegal = 1'b1;
                end
                default: begin
                    next_state = FETCH;
                end
            endcase
        end
    end

    assign bus.instr_done  = done;
    assign bus.instr_count = count;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one instance with defaults, one with CNT_W=4 and addi disabled.
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   checks = 0;
    int   fails  = 0;
    logic [31:0] exp_cnt0;
    logic [3:0]  exp_cnt1;

    mips_multicycle_ctrl_if #(.CNT_W(32)) bus0 ();
    mips_multicycle_ctrl_if #(.CNT_W(4))  bus1 ();

    mips_multicycle_ctrl #(.CNT_W(32), .ENABLE_ADDI(1'b1)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    mips_multicycle_ctrl #(.CNT_W(4),  .ENABLE_ADDI(1'b0)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    always #5 clk = ~clk;

    // Field order: alu_op, src_a, src_b, pc_source, pc_write, pc_write_cond, iord, mem_read,
    // mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal
    localparam logic [17:0] S_ZERO        = '0;
    localparam logic [17:0] S_FETCH       = {2'b00,1'b0,2'b01,2'b00,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] S_FETCH_STALL = {2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] S_DECODE      = {2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] S_MEMADR      = {2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] S_MEMRD       = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] S_MEMWB       = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0};
    localparam logic [17:0] S_MEMWR_STALL = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] S_MEMWR_DONE  = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam logic [17:0] S_EXEC        = {2'b10,1'b1,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] S_RWB         = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0};
    localparam logic [17:0] S_BRANCH      = {2'b01,1'b1,2'b00,2'b01,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam logic [17:0] S_JUMP        = {2'b00,1'b0,2'b00,2'b10,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam logic [17:0] S_ADDI_EX     = {2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [17:0] S_ADDI_WB     = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
    localparam logic [17:0] S_TRAP        = {2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};

    logic [17:0] ctl0;
    logic [17:0] ctl1;
    assign ctl0 = {bus0.alu_op, bus0.alu_src_a, bus0.alu_src_b, bus0.pc_source, bus0.pc_write,
                   bus0.pc_write_cond, bus0.iord, bus0.mem_read, bus0.mem_write, bus0.ir_write,
                   bus0.reg_dst, bus0.mem_to_reg, bus0.reg_write, bus0.instr_done, bus0.illegal};
    assign ctl1 = {bus1.alu_op, bus1.alu_src_a, bus1.alu_src_b, bus1.pc_source, bus1.pc_write,
                   bus1.pc_write_cond, bus1.iord, bus1.mem_read, bus1.mem_write, bus1.ir_write,
                   bus1.reg_dst, bus1.mem_to_reg, bus1.reg_write, bus1.instr_done, bus1.illegal};

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (ctl0 !== S_ZERO || bus0.instr_count !== 32'd0) begin
            fails++;
            $display("[TB] FAIL reset0: ctl=%h cnt=%0d, expected ctl=%h cnt=0", ctl0, bus0.instr_count, S_ZERO);
        end
        checks++;
        if (ctl1 !== S_ZERO || bus1.instr_count !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset1: ctl=%h cnt=%0d, expected ctl=%h cnt=0", ctl1, bus1.instr_count, S_ZERO);
        end
        exp_cnt0 = 32'd0;
        exp_cnt1 = 4'd0;
    endtask

    task automatic test_rtype();
        logic [17:0] ex [4] = '{S_FETCH, S_DECODE, S_EXEC, S_RWB};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst0 = 1'b0; bus0.mem_ready = 1'b1; bus0.opcode = 6'b000000;
            #1;
            checks++;
            if (ctl0 !== ex[i] || bus0.instr_count !== exp_cnt0) begin
                fails++;
                $display("[TB] FAIL rtype cycle %0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl0, bus0.instr_count, ex[i], exp_cnt0);
            end
            if (ex[i][1]) exp_cnt0++;
        end
    endtask

    task automatic test_lw_stall();
        logic [17:0] ex [7] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
        logic [0:6]  mr = 7'b1110011;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rst0 = 1'b0; bus0.mem_ready = mr[i]; bus0.opcode = 6'b100011;
            #1;
            checks++;
            if (ctl0 !== ex[i] || bus0.instr_count !== exp_cnt0) begin
                fails++;
                $display("[TB] FAIL lw_stall cycle %0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl0, bus0.instr_count, ex[i], exp_cnt0);
            end
            if (ex[i][1]) exp_cnt0++;
        end
    endtask

    task automatic test_sw_stall();
        logic [17:0] ex [6] = '{S_FETCH_STALL, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR_STALL, S_MEMWR_DONE};
        logic [0:5]  mr = 6'b010001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst0 = 1'b0; bus0.mem_ready = mr[i]; bus0.opcode = 6'b101011;
            #1;
            checks++;
            if (ctl0 !== ex[i] || bus0.instr_count !== exp_cnt0) begin
                fails++;
                $display("[TB] FAIL sw_stall cycle %0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl0, bus0.instr_count, ex[i], exp_cnt0);
            end
            if (ex[i][1]) exp_cnt0++;
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] ex [6] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_JUMP};
        logic [5:0]  op [6] = '{6'b111111, 6'b000100, 6'b000100, 6'b111111, 6'b000010, 6'b000010};
        logic [0:5]  mr = 6'b110110;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst0 = 1'b0; bus0.mem_ready = mr[i]; bus0.opcode = op[i];
            #1;
            checks++;
            if (ctl0 !== ex[i] || bus0.instr_count !== exp_cnt0) begin
                fails++;
                $display("[TB] FAIL beq_j cycle %0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl0, bus0.instr_count, ex[i], exp_cnt0);
            end
            if (ex[i][1]) exp_cnt0++;
        end
    endtask

    task automatic test_addi();
        logic [17:0] ex [4] = '{S_FETCH, S_DECODE, S_ADDI_EX, S_ADDI_WB};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst0 = 1'b0; bus0.mem_ready = 1'b1; bus0.opcode = 6'b001000;
            #1;
            checks++;
            if (ctl0 !== ex[i] || bus0.instr_count !== exp_cnt0) begin
                fails++;
                $display("[TB] FAIL addi cycle %0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl0, bus0.instr_count, ex[i], exp_cnt0);
            end
            if (ex[i][1]) exp_cnt0++;
        end
    endtask

    task automatic test_trap();
        logic [17:0] ex [7] = '{S_FETCH, S_DECODE, S_TRAP, S_TRAP, S_TRAP, S_ZERO, S_FETCH_STALL};
        logic [5:0]  op [7] = '{6'b111111, 6'b111111, 6'b111111, 6'b111111, 6'b000000, 6'b000000, 6'b000000};
        logic [0:6]  mr = 7'b1101010;
        logic [0:6]  rs = 7'b0000010;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rst0 = rs[i]; bus0.mem_ready = mr[i]; bus0.opcode = op[i];
            #1;
            checks++;
            if (ctl0 !== ex[i] || bus0.instr_count !== exp_cnt0) begin
                fails++;
                $display("[TB] FAIL trap cycle %0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl0, bus0.instr_count, ex[i], exp_cnt0);
            end
            if (rs[i]) exp_cnt0 = 32'd0;
            else if (ex[i][1]) exp_cnt0++;
        end
    endtask

    task automatic test_reset_mid_write();
        logic [17:0] ex [6] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR_STALL, S_ZERO, S_FETCH_STALL};
        logic [0:5]  mr = 6'b111000;
        logic [0:5]  rs = 6'b000010;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst0 = rs[i]; bus0.mem_ready = mr[i]; bus0.opcode = 6'b101011;
            #1;
            checks++;
            if (ctl0 !== ex[i] || bus0.instr_count !== exp_cnt0) begin
                fails++;
                $display("[TB] FAIL reset_mid_write cycle %0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl0, bus0.instr_count, ex[i], exp_cnt0);
            end
            if (rs[i]) exp_cnt0 = 32'd0;
            else if (ex[i][1]) exp_cnt0++;
        end
    endtask

    task automatic test_addi_disabled();
        logic [17:0] ex [5] = '{S_FETCH, S_DECODE, S_TRAP, S_ZERO, S_FETCH_STALL};
        logic [0:4]  mr = 5'b11100;
        logic [0:4]  rs = 5'b00010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst1 = rs[i]; bus1.mem_ready = mr[i]; bus1.opcode = 6'b001000;
            #1;
            checks++;
            if (ctl1 !== ex[i] || bus1.instr_count !== exp_cnt1) begin
                fails++;
                $display("[TB] FAIL addi_disabled cycle %0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", i, ctl1, bus1.instr_count, ex[i], exp_cnt1);
            end
            if (rs[i]) exp_cnt1 = 4'd0;
            else if (ex[i][1]) exp_cnt1++;
        end
    endtask

    task automatic test_count_wrap();
        logic [17:0] ex [3] = '{S_FETCH, S_DECODE, S_JUMP};
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                rst1 = 1'b0; bus1.mem_ready = 1'b1; bus1.opcode = 6'b000010;
                #1;
                checks++;
                if (ctl1 !== ex[k] || bus1.instr_count !== exp_cnt1) begin
                    fails++;
                    $display("[TB] FAIL count_wrap jump %0d cycle %0d: ctl=%h cnt=%0d, expected ctl=%h cnt=%0d", n, k, ctl1, bus1.instr_count, ex[k], exp_cnt1);
                end
                if (ex[k][1]) exp_cnt1++;
            end
        end
        @(negedge clk);
        bus1.mem_ready = 1'b0;
        #1;
        checks++;
        if (ctl1 !== S_FETCH_STALL || bus1.instr_count !== 4'd0) begin
            fails++;
            $display("[TB] FAIL count_wrap final: ctl=%h cnt=%0d, expected ctl=%h cnt=0", ctl1, bus1.instr_count, S_FETCH_STALL);
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.mem_ready = 1'b1;
        bus0.opcode    = 6'b000000;
        bus1.mem_ready = 1'b1;
        bus1.opcode    = 6'b000000;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_stall();
        test_back_to_back();
        test_addi();
        test_trap();
        test_reset_mid_write();
        test_addi_disabled();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
